adder_share_arbiter: RTL and testbench

- Shares one N-bit carry-lookahead adder among NUM_REQ requesters in the ODE accelerator fixed-point datapath.
- Each requester issues an add or subtract over a valid/ready handshake.
- A round-robin arbiter grants one requester at a time and latches its operands.
- The block drives the shared adder, then holds the registered result, flags and requester ID until the consumer accepts it.

---
 rtl/adder_share_pkg.sv | 10 +
 rtl/adder_share_arbiter_rr_arbiter.sv | 27 ++
 rtl/carry_lookahead_adder.sv | 32 +++
 rtl/adder_share_arbiter.sv | 100 ++++++++++
 tb/tb_adder_share_arbiter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared state encoding and op codes for adder_share_arbiter
package adder_share_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_RESP    = 2'd2
    } state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr and wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] sel;
    // Walk offsets from farthest to nearest so the closest requester to ptr wins
    always_comb begin
        grant = '0;
        idx   = '0;
        sel   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sel = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (en && req[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end
endmodule

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: N-bit adder with parallel-prefix generate/propagate carries
module carry_lookahead_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N-1:0] gk, pk, gn, pn;
    // gk[i] ends up as the carry out of bit i, with cin folded into bit 0
    always_comb begin
        gk = a & b;
        pk = a ^ b;
        gk[0] = gk[0] | (pk[0] & cin);
        gn = gk;
        pn = pk;
        for (int s = 1; s < N; s = s * 2) begin
            gn = gk;
            pn = pk;
            for (int i = s; i < N; i++) begin
                gn[i] = gk[i] | (pk[i] & gk[i-s]);
                pn[i] = pk[i] & pk[i-s];
            end
            gk = gn;
            pk = pn;
        end
    end
    assign sum  = (a ^ b) ^ {gk[N-2:0], cin};
    assign cout = gk[N-1];
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one carry-lookahead adder among NUM_REQ add/sub requesters
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int N       = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_sub,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [N-1:0]         resp_result,
    output logic                 resp_carry,
    output logic                 resp_overflow,
    output logic                 resp_negative
);
    state_t            state;
    logic [ID_W-1:0]   ptr, idx, id_q;
    logic [N-1:0]      a_q, b_q, sum, b_sel;
    logic              cin_q, cout, ovf, sub_sel, arb_en, any;
    logic [NUM_REQ-1:0] grant;

    // Gating with rst_n keeps req_ready low while reset is asserted
    assign arb_en = rst_n && (state == ST_IDLE || (state == ST_RESP && resp_ready));

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant),
        .idx   (idx)
    );

    assign req_ready = grant;
    assign any       = |grant;
    assign sub_sel   = (req_sub[idx] == OP_SUB);
    assign b_sel     = sub_sel ? ~req_b[idx*N +: N] : req_b[idx*N +: N];

    carry_lookahead_adder #(.N(N)) u_add (
        .a    (a_q),
        .b    (b_q),
        .cin  (cin_q),
        .sum  (sum),
        .cout (cout)
    );

    // Same-sign operands producing an opposite-sign sum equals carry-in-to-MSB xor carry-out
    assign ovf = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= OP_ADD;
            id_q          <= '0;
            resp_valid    <= 1'b0;
            resp_id       <= '0;
            resp_result   <= '0;
            resp_carry    <= 1'b0;
            resp_overflow <= 1'b0;
            resp_negative <= 1'b0;
        end else begin
            if (any) begin
                a_q   <= req_a[idx*N +: N];
                b_q   <= b_sel;
                cin_q <= sub_sel;
                id_q  <= idx;
                ptr   <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
            case (state)
                ST_IDLE: state <= any ? ST_COMPUTE : ST_IDLE;
                ST_COMPUTE: begin
                    resp_valid    <= 1'b1;
                    resp_id       <= id_q;
                    resp_result   <= sum;
                    resp_carry    <= cout;
                    resp_overflow <= ovf;
                    resp_negative <= ovf ^ sum[N-1];
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= any ? ST_COMPUTE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and randomized checks against a transaction-level model
module tb_adder_share_arbiter;
    localparam int N = 16;
    localparam int R = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [R-1:0]   rv = '0, rs = '0;
    logic [R*N-1:0] ra = '0, rb = '0;
    logic           rr = 1'b0;
    logic [R-1:0]   req_ready;
    logic           resp_valid, resp_carry, resp_overflow, resp_negative;
    logic [1:0]     resp_id;
    logic [N-1:0]   resp_result;

    always #5 clk = ~clk;

    adder_share_arbiter #(.N(N), .NUM_REQ(R), .ID_W(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (rv),
        .req_ready     (req_ready),
        .req_a         (ra),
        .req_b         (rb),
        .req_sub       (rs),
        .resp_valid    (resp_valid),
        .resp_ready    (rr),
        .resp_id       (resp_id),
        .resp_result   (resp_result),
        .resp_carry    (resp_carry),
        .resp_overflow (resp_overflow),
        .resp_negative (resp_negative)
    );

    int tests = 0, fails = 0;
    int cyc = 0, ptr_m = 0, valid_at = 0, last_grant = -1, op_id = 0;
    bit has_op = 0;
    logic [N-1:0] op_a, op_b;
    logic op_sub;
    logic [R-1:0] s_ready;
    int order [6] = '{0, 1, 2, 3, 0, 1};

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int winner(logic [R-1:0] v, int p);
        logic [R-1:0] t;
        for (int k = 0; k < R; k++) begin
            t = v >> ((p + k) % R);
            if (t[0]) return (p + k) % R;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] cs [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        if ($urandom % 3 == 0) return cs[$urandom % 5];
        return 16'($urandom);
    endfunction

    task automatic model_reset();
        has_op = 0;
        ptr_m = 0;
        last_grant = -1;
    endtask

    // One clock cycle: compare at negedge against the model, then advance the model
    task automatic step();
        logic ev, ec, eo, en;
        logic signed [17:0] ex;
        logic [R-1:0] eg;
        int w;
        @(negedge clk);
        ev = has_op && cyc >= valid_at;
        w = (!has_op || (ev && rr)) ? winner(rv, ptr_m) : -1;
        eg = (w >= 0) ? R'(1 << w) : '0;
        s_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(eg));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        if (ev) begin
            ex = op_sub ? $signed({{2{op_a[N-1]}}, op_a}) - $signed({{2{op_b[N-1]}}, op_b})
                        : $signed({{2{op_a[N-1]}}, op_a}) + $signed({{2{op_b[N-1]}}, op_b});
            ec = op_sub ? (op_a >= op_b) : (({1'b0, op_a} + {1'b0, op_b}) > 17'h0FFFF);
            eo = (ex > 32767) || (ex < -32768);
            en = ex < 0;
            chk("resp_id", 32'(resp_id), 32'(op_id));
            chk("resp_result", 32'(resp_result), 32'(ex[N-1:0]));
            chk("resp_carry", 32'(resp_carry), 32'(ec));
            chk("resp_overflow", 32'(resp_overflow), 32'(eo));
            chk("resp_negative", 32'(resp_negative), 32'(en));
        end
        if (ev && rr) has_op = 0;
        if (w >= 0) begin
            has_op = 1;
            op_id = w;
            op_a = ra[w*N +: N];
            op_b = rb[w*N +: N];
            op_sub = rs[w];
            valid_at = cyc + 2;
            ptr_m = (w + 1) % R;
        end
        last_grant = w;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [N-1:0] a, logic [N-1:0] b, logic sub);
        ra[i*N +: N] = a;
        rb[i*N +: N] = b;
        rs[i] = sub;
        rv[i] = 1'b1;
    endtask

    task automatic one_op(int i, logic [N-1:0] a, logic [N-1:0] b, logic sub,
                          logic [N-1:0] er, logic ec, logic eo, logic en);
        rv = '0;
        rr = 1'b0;
        set_req(i, a, b, sub);
        step();
        rv[i] = 1'b0;
        step();
        chk("dir_valid", 32'(resp_valid), 32'd1);
        chk("dir_id", 32'(resp_id), 32'(i));
        chk("dir_result", 32'(resp_result), 32'(er));
        chk("dir_carry", 32'(resp_carry), 32'(ec));
        chk("dir_overflow", 32'(resp_overflow), 32'(eo));
        chk("dir_negative", 32'(resp_negative), 32'(en));
        rr = 1'b1;
        step();
        rr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rv = '1;
        rr = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        chk("rst_flags", 32'({resp_id, resp_carry, resp_overflow, resp_negative}), 32'd0);
        rv = '0;
        rr = 1'b0;
        rst_n = 1'b1;
        model_reset();

        one_op(0, 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
        one_op(2, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
        one_op(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        one_op(1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);

        // Reset while an operation sits in COMPUTE
        set_req(3, 16'h1234, 16'h1111, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < R; i++) set_req(i, 16'(i * 256 + 1), 16'h0003, i[0]);
        rr = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k % 2 == 0) chk("fair_order", 32'(s_ready), 32'(1 << order[k/2]));
        end

        rr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_ready", 32'(s_ready), 32'd0);
        end
        rr = 1'b1;
        step();
        chk("bp_regrant", 32'(s_ready), 32'b0100);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < R; i++) begin
                if (last_grant == i || !rv[i]) begin
                    rv[i] = ($urandom % 3) != 0;
                    ra[i*N +: N] = rnd();
                    rb[i*N +: N] = rnd();
                    rs[i] = 1'($urandom % 2);
                end else if ($urandom % 20 == 0) begin
                    rv[i] = 1'b0;
                end
            end
            rr = ($urandom % 4) != 0;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
